// File: rtl/alu_arb_seq.sv
// alu_arb_seq: round-robin arbiter sequencing two requesters onto one shared combinational ALU
module alu_arb_seq #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [3:0] req0_op,
  input  logic [3:0] req1_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [8:0] alu_res,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [8:0] rsp_data,
  output logic       rsp_id,
  output logic       rsp_err
  ,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t     state;
  logic       ptr;
  logic       gnt;
  logic       gnt_id;
  logic       accept;
  logic [3:0] cnt;
  logic       illegal;
  // Grant decision: lone requester wins, contention resolved by the priority pointer
  always_comb begin
    gnt        = (req0_valid && req1_valid) ? ptr : req1_valid;
    accept     = (state == IDLE) && !rst && (req0_valid || req1_valid);
    req0_ready = accept && !gnt;
    req1_ready = accept && gnt;
    illegal    = alu_op > 4'hA;
  end
  // Sequencer: accept in IDLE, hold operands for EXEC_CYCLES, present result until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      cnt       <= '0;
      gnt_id    <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          alu_a  <= gnt ? req1_a : req0_a;
          alu_b  <= gnt ? req1_b : req0_b;
          alu_op <= gnt ? req1_op : req0_op;
          gnt_id <= gnt;
          ptr    <= ~gnt;
          cnt    <= '0;
          busy   <= 1'b1;
          state  <= EXEC;
        end
        EXEC: if (cnt == 4'(EXEC_CYCLES - 1)) begin
          rsp_data  <= illegal ? '0 : alu_res;
          rsp_err   <= illegal;
          rsp_id    <= gnt_id;
          rsp_valid <= 1'b1;
          cnt       <= '0;
          state     <= RESP;
        end else begin
          cnt <= cnt + 4'd1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          alu_a     <= '0;
          alu_b     <= '0;
          alu_op    <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arb_seq.sv
// tb_alu_arb_seq: directed checks of alu_arb_seq with EXEC_CYCLES of 1 and 4
module tb_alu_arb_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic       r0v = 1'b0, r1v = 1'b0, r0r, r1r, rr = 1'b1, rv, rid, rerr, bsy;
  logic [7:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0, aa, ab;
  logic [3:0] r0o = '0, r1o = '0, ao;
  logic [8:0] ares, rd;
  logic       qv = 1'b0, qr, q1r, qrv, qid, qerr, qbsy;
  logic [7:0] qa = '0, qb = '0, qaa, qab;
  logic [3:0] qo = '0, qao;
  logic [8:0] qres, qrd;
  int n_cmp = 0;
  int n_err = 0;
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    case (op)
      4'h0: return {1'b0, a};
      4'h1: return {1'b0, a} + {1'b0, b};
      4'h2: return {1'b0, a} - {1'b0, b};
      4'h3: return {1'b0, a & b};
      4'hA: return {1'b0, b};
      default: return 9'h1FF;
    endcase
  endfunction
  assign ares = alu_f(aa, ab, ao);
  assign qres = alu_f(qaa, qab, qao);
  alu_arb_seq #(.EXEC_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req1_valid(r1v), .req0_ready(r0r), .req1_ready(r1r),
    .req0_a(r0a), .req0_b(r0b), .req1_a(r1a), .req1_b(r1b), .req0_op(r0o), .req1_op(r1o),
    .alu_a(aa), .alu_b(ab), .alu_op(ao), .alu_res(ares),
    .rsp_valid(rv), .rsp_ready(rr), .rsp_data(rd), .rsp_id(rid), .rsp_err(rerr), .busy(bsy)
  );
  alu_arb_seq #(.EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(qv), .req1_valid(1'b0), .req0_ready(qr), .req1_ready(q1r),
    .req0_a(qa), .req0_b(qb), .req1_a(8'h00), .req1_b(8'h00), .req0_op(qo), .req1_op(4'h0),
    .alu_a(qaa), .alu_b(qab), .alu_op(qao), .alu_res(qres),
    .rsp_valid(qrv), .rsp_ready(1'b1), .rsp_data(qrd), .rsp_id(qid), .rsp_err(qerr), .busy(qbsy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic single(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input logic [8:0] d, input logic e);
    r0v = !id; r1v = id;
    r0a = a; r0b = b; r0o = op; r1a = a; r1b = b; r1o = op;
    #1;
    chk("acc_rdy", {r0r, r1r}, id ? 2'b01 : 2'b10);
    tick;
    r0v = 1'b0; r1v = 1'b0;
    #1;
    chk("exec_busy", bsy, 1);
    chk("exec_op", ao, op);
    chk("exec_ab", {aa, ab}, {a, b});
    chk("exec_rv", rv, 0);
    chk("exec_rdy", {r0r, r1r}, 0);
    tick;
    chk("resp_rv", rv, 1);
    chk("resp_data", rd, d);
    chk("resp_id", rid, id);
    chk("resp_err", rerr, e);
    tick;
    chk("done_rv", rv, 0);
    chk("done_busy", bsy, 0);
    chk("done_op", ao, 0);
  endtask
  initial begin
    r0v = 1'b1;
    tick;
    tick;
    chk("rst_rdy", {r0r, r1r}, 0);
    chk("rst_outs", {rv, bsy, ao, aa, ab, rd, rid, rerr}, 0);
    chk("rst_outs4", {qrv, qbsy, qao, qaa, qab, qrd, qid, qerr}, 0);
    rst = 1'b0; r0v = 1'b0;
    qv = 1'b1; qa = 8'h6B; qb = 8'hAA; qo = 4'h2;
    #1;
    chk("e4_rdy", {qr, q1r}, 2'b10);
    tick;
    qv = 1'b0; qo = 4'h7;
    for (int k = 0; k < 4; k++) begin
      chk("e4_op", qao, 2);
      chk("e4_rv", qrv, 0);
      tick;
    end
    chk("e4_rv_hi", qrv, 1);
    chk("e4_data", qrd, 9'h1C1);
    tick;
    chk("e4_idle", {qrv, qbsy, qao}, 0);
    single(1'b0, 8'h6B, 8'hAA, 4'h1, 9'h115, 1'b0);
    single(1'b0, 8'h6B, 8'hAA, 4'h2, 9'h1C1, 1'b0);
    single(1'b0, 8'h6B, 8'hAA, 4'hA, 9'h0AA, 1'b0);
    single(1'b1, 8'h6B, 8'hAA, 4'hC, 9'h000, 1'b1);
    r0v = 1'b1; r1v = 1'b1; rr = 1'b0;
    r0a = 8'h01; r0b = 8'h02; r0o = 4'h1; r1a = 8'h00; r1b = 8'h00; r1o = 4'h0;
    #1;
    chk("bp_rdy", {r0r, r1r}, 2'b10);
    tick;
    chk("bp_exec_rdy", {r0r, r1r}, 0);
    tick;
    chk("bp_rv", rv, 1);
    chk("bp_data", rd, 9'h003);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("bp_hold", {rv, rd, rid, rerr, bsy}, {1'b1, 9'h003, 1'b0, 1'b0, 1'b1});
      chk("bp_hold_rdy", {r0r, r1r}, 0);
    end
    r0v = 1'b0; r1v = 1'b0; rr = 1'b1;
    tick;
    chk("bp_release", {rv, bsy}, 0);
    r0v = 1'b1; r0a = 8'h10; r0b = 8'h20; r0o = 4'h1;
    tick;
    r0v = 1'b0;
    #1;
    chk("mid_busy", bsy, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_outs", {rv, bsy, ao, aa, ab, rd, rid, rerr}, 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("mid_no_rsp", rv, 0);
    end
    single(1'b0, 8'hF0, 8'h3C, 4'h3, 9'h030, 1'b0);
    rst = 1'b1; r0v = 1'b1; r1v = 1'b1;
    r0a = 8'h01; r0b = 8'h01; r0o = 4'h1; r1a = 8'h05; r1b = 8'h00; r1o = 4'h0;
    tick;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("ct_grant", {r0r, r1r}, i[0] ? 2'b01 : 2'b10);
      tick;
      chk("ct_exec_rdy", {r0r, r1r}, 0);
      tick;
      chk("ct_rv", rv, 1);
      chk("ct_id", rid, i[0]);
      chk("ct_data", rd, i[0] ? 9'h005 : 9'h002);
      chk("ct_resp_rdy", {r0r, r1r}, 0);
      tick;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arb_seq.md
ALU_ARB_SEQ -- requirements
Module: alu_arb_seq

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, meaning the number of cycles operands are held on the ALU before the result is captured; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 each, requester N has an operation pending.
REQ-005 SHALL have ports req0_ready and req1_ready, output, 1 each, requester N's operation is accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a and req1_b, input, 8 each, operands of requester N.
REQ-007 SHALL have ports req0_op and req1_op, input, 4 each, opcode of requester N.
REQ-008 SHALL have ports alu_a and alu_b, output, 8 each, registered operands driven to the shared ALU.
REQ-009 SHALL have port alu_op, output, 4, registered opcode driven to the shared ALU.
REQ-010 SHALL have port alu_res, input, 9, combinational result from the shared ALU.
REQ-011 SHALL have port rsp_valid, output, 1, response available.
REQ-012 SHALL have port rsp_ready, input, 1, consumer accepts the response.
REQ-013 SHALL have port rsp_data, output, 9, captured result.
REQ-014 SHALL have port rsp_id, output, 1, index of the requester that owns the response.
REQ-015 SHALL have port rsp_err, output, 1, the opcode was illegal.
REQ-016 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, EXEC and RESP.
REQ-018 SHALL behave as follows in IDLE with at least one reqN_valid:
- grant one requester and assert only its reqN_ready combinationally;
- latch that requester's a, b and op into the ALU registers;
- latch the granted index;
- go to EXEC.
REQ-019 SHALL hold both reqN_ready low in EXEC, in RESP, and during rst.
REQ-020 SHALL arbitrate round-robin:
- a single valid requester wins;
- with both valid, the requester named by a 1-bit priority pointer wins;
- after any grant the pointer points to the other requester.
REQ-021 SHALL hold alu_a, alu_b and alu_op stable for exactly EXEC_CYCLES cycles in EXEC, counted by a 4-bit counter.
REQ-022 SHALL, on the last EXEC cycle, register alu_res into rsp_data and the granted index into rsp_id, then go to RESP.
REQ-023 SHALL treat opcodes 4'b1011..4'b1111 as illegal:
- the opcode is still issued;
- rsp_data is forced to 9'h000;
- rsp_err is 1.
REQ-024 SHALL set rsp_err to 0 for legal opcodes 4'b0000..4'b1010.
REQ-025 SHALL assert rsp_valid in RESP only.
REQ-026 SHALL hold rsp_data, rsp_id and rsp_err stable while rsp_valid=1 and rsp_ready=0.
REQ-027 SHALL, in RESP with rsp_ready=1:
- complete the transfer;
- deassert rsp_valid next cycle;
- go to IDLE.
REQ-028 SHALL NOT accept a new request in the cycle the response completes.
REQ-029 SHALL drive alu_a, alu_b and alu_op to 0 on entering IDLE.
REQ-030 SHALL give a latency of EXEC_CYCLES+1 cycles from the accept edge to rsp_valid high, and a minimum issue interval of EXEC_CYCLES+2 cycles.
REQ-031 SHALL ignore reqN_valid edges and reqN operand changes outside the accept cycle.

Reset
REQ-032 SHALL, on rst=1 at a clock edge:
- state goes to IDLE;
- pointer goes to 0 (req0 favoured);
- counter goes to 0;
- rsp_valid, rsp_data, rsp_id, rsp_err, alu_a, alu_b, alu_op and busy all go to 0.
REQ-033 SHALL abandon an in-flight operation when rst is asserted in EXEC or RESP, with no response ever produced for it.
REQ-034 SHALL give rst priority over every simultaneous handshake event.

Verification
REQ-035 SHALL cover single requests, EXEC_CYCLES=1, req0 a=8'h6B b=8'hAA:
- op=0001 -> rsp_valid two cycles after accept, rsp_data=9'h115, rsp_id=0, rsp_err=0;
- op=0010 -> 9'h1C1;
- op=1010 -> 9'h0AA.
REQ-036 SHALL cover contention: req0 and req1 both valid continuously from reset release -> grant order req0, req1, req0, req1 with matching rsp_id; never two readys in one cycle.
REQ-037 SHALL cover an illegal opcode: req1 op=4'b1100 -> alu_op=1100 during EXEC, rsp_data=9'h000, rsp_err=1, rsp_id=1.
REQ-038 SHALL cover backpressure: rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_data stable, both reqN_ready low, busy=1; on release, IDLE the next cycle.
REQ-039 SHALL cover reset mid-operation: rst pulsed in EXEC -> rsp_valid never asserts for that op, all outputs 0, the next request gets a normal response.
REQ-040 SHALL cover EXEC_CYCLES=4: alu_op stable 4 cycles, rsp_valid 5 cycles after accept.
